vga_box_pixel_gen: RTL
======================

Name: vga_box_pixel_gen

Overview:
Pixel-source stage that sits directly upstream of the VGA controller's colour outputs. It takes the controller's horizontal and vertical counter values and produces registered 4-bit RGB for each pixel. The picture is a solid square that moves across the 640x480 active area. The square bounces off the edges and changes colour on each bounce, with all motion updated once per frame during vertical blanking.

Parameters:
- H_ACTIVE_START, 144, first h_count value of the active region (inclusive).
- H_ACTIVE_END, 784, end of the active region (exclusive); active width 640.
- V_ACTIVE_START, 35, first v_count value of the active region (inclusive).
- V_ACTIVE_END, 515, end of the active region (exclusive); active height 480. Also the frame-update trigger line.
- BOX_SIZE, 32, side length of the square in pixels.
- STEP, 4, pixels moved per frame on each axis.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- h_count  in  16  horizontal counter from the timing stage.
- v_count  in  16  vertical counter from the timing stage.
- pause  in  1  1 = freeze position and colour; frame_tick still pulses.
- Red  out  4  red pixel value.
- Green  out  4  green pixel value.
- Blue  out  4  blue pixel value.
- frame_tick  out  1  one-cycle pulse when the per-frame update starts.
- box_x  out  10  square left edge, relative to the active area.
- box_y  out  10  square top edge, relative to the active area.

Behaviour:
- Reset (rst=0, asynchronous):
  - Red/Green/Blue=0, frame_tick=0, box_x=0, box_y=0.
  - Direction right and down; colour index 0; FSM in IDLE; trigger history cleared.
- Pixel path, 1-cycle latency:
  - active = H_ACTIVE_START<=h_count<H_ACTIVE_END and V_ACTIVE_START<=v_count<V_ACTIVE_END.
  - px = h_count-H_ACTIVE_START; py = v_count-V_ACTIVE_START.
  - in_box = box_x<=px<box_x+BOX_SIZE and box_y<=py<box_y+BOX_SIZE.
  - RGB registered on the next clk edge: palette[colour index] if active and in_box; otherwise 12'h000.
  - Comparisons use 16-bit unsigned arithmetic, so there is no wrap.
- Palette (idx: R,G,B): 0:F,F,F; 1:F,0,0; 2:0,F,0; 3:0,0,F; 4:F,F,0; 5:0,F,F; 6:F,0,F; 7:8,8,8.
- Trigger:
  - trig = (h_count==0 and v_count==V_ACTIVE_END).
  - Fires only on a 0->1 transition of trig, using a registered previous value.
  - Ignored unless the FSM is in IDLE.
- FSM states IDLE -> MOVE_X -> MOVE_Y -> IDLE, one cycle per state:
  - IDLE: on trigger, go to MOVE_X; frame_tick=1 on the following cycle (registered), then 0.
  - MOVE_X (skipped as no-op if pause=1):
    - Moving right: if box_x+STEP > 640-BOX_SIZE, set box_x=640-BOX_SIZE, reverse to left, set bounce flag; else box_x+=STEP.
    - Moving left: if box_x < STEP, set box_x=0, reverse to right, set bounce flag; else box_x-=STEP.
  - MOVE_Y: same rules on box_y with limit 480-BOX_SIZE (no-op if pause=1).
    - If the bounce flag is set, colour index += 1 mod 8, incremented once even on a corner (both-axis) bounce.
    - Clear the bounce flag and return to IDLE.
- pause is sampled in each MOVE state; a change mid-update affects only the remaining state.
- box_x updates at the end of MOVE_X; box_y and colour update at the end of MOVE_Y. Both land during vblank, so there is no tearing.
- A reset asserted mid-update aborts the update immediately and restores all reset values.

Test Plan:
- Reset: hold rst=0, drive counts inside the active area -> RGB=000, box_x=box_y=0, frame_tick=0; release -> no change until a trigger.
- Pixel edges, at reset position:
  - h=144, v=35 -> RGB=FFF one cycle later.
  - h=143 -> 000.
  - h=176, v=35 (px=32) -> 000.
  - h=175, v=66 -> FFF.
- One frame: step h_count through 0 at v_count=515 -> frame_tick high for exactly 1 cycle; box_x=4 after MOVE_X; box_y=4 after MOVE_Y; colour index stays 0.
- Y bounce:
  - 112 frames -> box_y=448, no bounce yet.
  - Frame 113 -> box_y=448, direction up, palette idx 1, in-box pixel RGB=F00.
  - Frame 114 -> box_y=444.
- X bounce and hold:
  - Frame 152 -> box_x=608.
  - Frame 153 -> box_x=608, reverses, idx 2 (0F0).
  - Hold trig high for 3 cycles -> exactly one frame_tick.
- Pause and reset mid-update:
  - pause=1 for 5 frames -> 5 frame_ticks, position and colour unchanged.
  - rst=0 pulsed during MOVE_X -> all reset values; the next trigger gives box_x=4.

Source files
------------

// File: rtl/vga_box_pixel_gen.sv
// Pixel source for the VGA colour outputs: draws a solid square that bounces around
// the 640x480 active area, moving once per frame during vertical blanking.
module vga_box_pixel_gen #(
  parameter int unsigned H_ACTIVE_START = 144,
  parameter int unsigned H_ACTIVE_END   = 784,
  parameter int unsigned V_ACTIVE_START = 35,
  parameter int unsigned V_ACTIVE_END   = 515,
  parameter int unsigned BOX_SIZE       = 32,
  parameter int unsigned STEP           = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] h_count,
  input  logic [15:0] v_count,
  input  logic        pause,
  output logic [3:0]  Red,
  output logic [3:0]  Green,
  output logic [3:0]  Blue,
  output logic        frame_tick,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y
);

  localparam logic [15:0] H_START = 16'(H_ACTIVE_START);
  localparam logic [15:0] H_END   = 16'(H_ACTIVE_END);
  localparam logic [15:0] V_START = 16'(V_ACTIVE_START);
  localparam logic [15:0] V_END   = 16'(V_ACTIVE_END);
  localparam logic [15:0] SIZE16  = 16'(BOX_SIZE);
  localparam logic [15:0] STEP16  = 16'(STEP);
  localparam logic [9:0]  STEP10  = 10'(STEP);
  localparam logic [15:0] X_LIMIT = 16'(H_ACTIVE_END - H_ACTIVE_START - BOX_SIZE);
  localparam logic [15:0] Y_LIMIT = 16'(V_ACTIVE_END - V_ACTIVE_START - BOX_SIZE);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MOVE_X = 2'd1;
  localparam logic [1:0] MOVE_Y = 2'd2;

  logic [1:0]  state;
  logic        trig_q;
  logic        dir_right;
  logic        dir_down;
  logic        bounce;
  logic [2:0]  colour_idx;
  logic [11:0] rgb_q;

  logic        trig;
  logic        trig_rise;
  logic        active;
  logic        in_box;
  logic [15:0] px;
  logic [15:0] py;
  logic [15:0] x_ext;
  logic [15:0] y_ext;
  logic [11:0] pix_rgb;
  logic        x_bounce;
  logic        y_bounce;
  logic [9:0]  x_next;
  logic [9:0]  y_next;

  function automatic logic [11:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 12'hFFF;
      3'd1:    palette = 12'hF00;
      3'd2:    palette = 12'h0F0;
      3'd3:    palette = 12'h00F;
      3'd4:    palette = 12'hFF0;
      3'd5:    palette = 12'h0FF;
      3'd6:    palette = 12'hF0F;
      default: palette = 12'h888;
    endcase
  endfunction

  // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
  always_comb begin
    trig      = (h_count == 16'd0) && (v_count == V_END);
    trig_rise = trig && !trig_q;

    active = (h_count >= H_START) && (h_count < H_END) &&
             (v_count >= V_START) && (v_count < V_END);
    px     = h_count - H_START;
    py     = v_count - V_START;
    x_ext  = {6'd0, box_x};
    y_ext  = {6'd0, box_y};
    in_box = (px >= x_ext) && (px < x_ext + SIZE16) &&
             (py >= y_ext) && (py < y_ext + SIZE16);
    pix_rgb = (active && in_box) ? palette(colour_idx) : 12'h000;

    // A move that would overshoot the wall clamps to it and counts as a bounce.
    if (dir_right) begin
      x_bounce = (x_ext + STEP16) > X_LIMIT;
      x_next   = x_bounce ? X_LIMIT[9:0] : box_x + STEP10;
    end else begin
      x_bounce = x_ext < STEP16;
      x_next   = x_bounce ? 10'd0 : box_x - STEP10;
    end

    if (dir_down) begin
      y_bounce = (y_ext + STEP16) > Y_LIMIT;
      y_next   = y_bounce ? Y_LIMIT[9:0] : box_y + STEP10;
    end else begin
      y_bounce = y_ext < STEP16;
      y_next   = y_bounce ? 10'd0 : box_y - STEP10;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously,
  // so an update in flight is abandoned the moment rst goes low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      trig_q     <= 1'b0;
      dir_right  <= 1'b1;
      dir_down   <= 1'b1;
      bounce     <= 1'b0;
      colour_idx <= 3'd0;
      rgb_q      <= 12'h000;
      frame_tick <= 1'b0;
      box_x      <= 10'd0;
      box_y      <= 10'd0;
    end else begin
      trig_q     <= trig;
      rgb_q      <= pix_rgb;
      frame_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_rise) begin
            state      <= MOVE_X;
            frame_tick <= 1'b1;
          end
        end
        MOVE_X: begin
          if (!pause) begin
            box_x <= x_next;
            if (x_bounce) begin
              dir_right <= !dir_right;
              bounce    <= 1'b1;
            end
          end
          state <= MOVE_Y;
        end
        MOVE_Y: begin
          // Colour advances once per frame even when both axes bounce together.
          if (!pause) begin
            box_y <= y_next;
            if (y_bounce) dir_down <= !dir_down;
            if (bounce || y_bounce) colour_idx <= colour_idx + 3'd1;
          end
          bounce <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Red   = rgb_q[11:8];
  assign Green = rgb_q[7:4];
  assign Blue  = rgb_q[3:0];

endmodule
